// File: rtl/ddr5_read_counters.sv
// Read-path DQS timing controller: sequences preamble, data burst, interamble
// and postamble for each accepted read command and decodes the phase strobes.
module ddr5_read_counters (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rd_cmd,
    input  logic [2:0] i_precycle,
    input  logic [1:0] i_postcycle,
    input  logic [1:0] i_burstlength,
    output logic       o_dqs_gate,
    output logic       o_preamble_valid,
    output logic       o_rddata_valid,
    output logic [2:0] o_beat_idx,
    output logic       o_burst_done,
    output logic       o_interamble,
    output logic       o_postamble_done,
    output logic       o_busy,
    output logic       o_cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_INTER,
        S_POST
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] cur_last_q, cur_last_d;
    logic [1:0] cur_post_q, cur_post_d;
    logic       pend_q, pend_d;
    logic [2:0] pend_last_q, pend_last_d;
    logic [1:0] pend_post_q, pend_post_d;
    logic [2:0] pend_g_q, pend_g_d;
    logic       err_q, err_d;

    logic       cmd_q;
    logic [2:0] cmd_p_q;
    logic [1:0] cmd_post_q;
    logic [2:0] cmd_last_q;

    logic [2:0] p_clamp;
    logic [2:0] last_in;
    logic [2:0] need;
    logic [2:0] g_new;
    logic [2:0] g_sel;
    logic       fits;
    logic       acc;

    assign p_clamp = (i_precycle == 3'd0) ? 3'd1 :
                     (i_precycle > 3'd4)  ? 3'd4 : i_precycle;
    assign last_in = (i_burstlength == 2'b01) ? 3'd3 : 3'd7;

    // The command is registered first; the FSM acts on it one edge later,
    // which is what places the first DATA cycle at T+P+1.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cmd_q      <= 1'b0;
            cmd_p_q    <= '0;
            cmd_post_q <= '0;
            cmd_last_q <= '0;
        end else begin
            cmd_q <= i_rd_cmd;
            if (i_rd_cmd) begin
                cmd_p_q    <= p_clamp;
                cmd_post_q <= i_postcycle;
                cmd_last_q <= last_in;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_last_q  <= '0;
            cur_post_q  <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= '0;
            pend_post_q <= '0;
            pend_g_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_last_q  <= cur_last_d;
            cur_post_q  <= cur_post_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            pend_post_q <= pend_post_d;
            pend_g_q    <= pend_g_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_last_d  = cur_last_q;
        cur_post_d  = cur_post_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        pend_post_d = pend_post_q;
        pend_g_d    = pend_g_q;
        err_d       = 1'b0;
        acc         = 1'b0;
        g_sel       = '0;

        // Gap between end of the current burst and the new burst's first beat.
        need  = cur_last_q - cnt_q;
        fits  = (cmd_p_q >= need);
        g_new = cmd_p_q - need;

        if (cmd_q) begin
            unique case (state_q)
                S_IDLE, S_POST: acc = 1'b1;
                S_DATA: begin
                    if (!pend_q && fits) acc = 1'b1;
                    else                 err_d = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    state_d    = S_PRE;
                    cnt_d      = cmd_p_q - 3'd1;
                    cur_last_d = cmd_last_q;
                    cur_post_d = cmd_post_q;
                end
            end
            S_PRE: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == cur_last_q) begin
                    if (pend_q || acc) begin
                        g_sel      = pend_q ? pend_g_q    : g_new;
                        cur_last_d = pend_q ? pend_last_q : cmd_last_q;
                        cur_post_d = pend_q ? pend_post_q : cmd_post_q;
                        pend_d     = 1'b0;
                        if (g_sel == 3'd0) begin
                            state_d = S_DATA;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_INTER;
                            cnt_d   = g_sel - 3'd1;
                        end
                    end else if (cur_post_q != 2'd0) begin
                        state_d = S_POST;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (acc) begin
                        pend_d      = 1'b1;
                        pend_g_d    = g_new;
                        pend_last_d = cmd_last_q;
                        pend_post_d = cmd_post_q;
                    end
                end
            end
            S_INTER: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_POST: begin
                if (acc) begin
                    state_d    = S_PRE;
                    cnt_d      = cmd_p_q - 3'd1;
                    cur_last_d = cmd_last_q;
                    cur_post_d = cmd_post_q;
                end else if (cnt_q == {1'b0, cur_post_q - 2'd1}) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_dqs_gate       = (state_q != S_IDLE);
    assign o_preamble_valid = (state_q == S_PRE);
    assign o_rddata_valid   = (state_q == S_DATA);
    assign o_beat_idx       = (state_q == S_DATA) ? cnt_q : 3'd0;
    assign o_burst_done     = (state_q == S_DATA) && (cnt_q == cur_last_q);
    assign o_interamble     = (state_q == S_INTER);
    assign o_postamble_done = (state_q == S_POST) && (cnt_q == {1'b0, cur_post_q - 2'd1});
    assign o_busy           = (state_q != S_IDLE) || cmd_q || pend_q;
    assign o_cmd_err        = err_q;

endmodule

// File: tb/tb_ddr5_read_counters.sv
// Bench for ddr5_read_counters: per-cycle timeline model built from command
// acceptance rules, compared against the DUT for directed and random traffic.
module tb_ddr5_read_counters;

    localparam int LEN   = 160;
    localparam int S_IDL = 0;
    localparam int S_PRE = 1;
    localparam int S_DAT = 2;
    localparam int S_INT = 3;
    localparam int S_PST = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_rd_cmd = 1'b0;
    logic [2:0] i_precycle = 3'd0;
    logic [1:0] i_postcycle = 2'd0;
    logic [1:0] i_burstlength = 2'd0;
    logic       o_dqs_gate, o_preamble_valid, o_rddata_valid;
    logic [2:0] o_beat_idx;
    logic       o_burst_done, o_interamble, o_postamble_done, o_busy, o_cmd_err;

    int checks = 0;
    int errors = 0;

    bit          cmd_at [0:LEN-1];
    logic [2:0]  cp     [0:LEN-1];
    logic [1:0]  cq     [0:LEN-1];
    logic [1:0]  cb     [0:LEN-1];
    int          es     [0:LEN-1];
    int          eb     [0:LEN-1];
    bit          ed     [0:LEN-1];
    bit          epd    [0:LEN-1];
    bit          ee     [0:LEN-1];
    logic [10:0] obs    [0:LEN-1];

    ddr5_read_counters dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_rd_cmd         (i_rd_cmd),
        .i_precycle       (i_precycle),
        .i_postcycle      (i_postcycle),
        .i_burstlength    (i_burstlength),
        .o_dqs_gate       (o_dqs_gate),
        .o_preamble_valid (o_preamble_valid),
        .o_rddata_valid   (o_rddata_valid),
        .o_beat_idx       (o_beat_idx),
        .o_burst_done     (o_burst_done),
        .o_interamble     (o_interamble),
        .o_postamble_done (o_postamble_done),
        .o_busy           (o_busy),
        .o_cmd_err        (o_cmd_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [10:0] outs();
        return {o_busy, o_dqs_gate, o_preamble_valid, o_rddata_valid, o_beat_idx,
                o_burst_done, o_interamble, o_postamble_done, o_cmd_err};
    endfunction

    function automatic logic [10:0] expv(input int k);
        logic [2:0] b;
        b = (es[k] == S_DAT) ? 3'(eb[k]) : 3'd0;
        return {(es[k] != S_IDL) || cmd_at[k], es[k] != S_IDL, es[k] == S_PRE,
                es[k] == S_DAT, b, ed[k], es[k] == S_INT, epd[k], ee[k]};
    endfunction

    function automatic int clampp(input logic [2:0] p);
        if (p == 3'd0) return 1;
        if (p > 3'd4)  return 4;
        return int'(p);
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < LEN; k++) begin
            cmd_at[k] = 1'b0;
            cp[k] = 3'($urandom);
            cq[k] = 2'($urandom);
            cb[k] = 2'($urandom);
        end
    endtask

    task automatic set_cmd(input int t, input int p, input int q, input int bl);
        cmd_at[t] = 1'b1;
        cp[t] = 3'(p);
        cq[t] = 2'(q);
        cb[t] = 2'(bl);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_rd_cmd = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    // Fill cycles s.. with an optional preamble, a burst, the postamble, then idle.
    task automatic write_burst(input int s, input int pl, input int q, input int n);
        for (int c = s; c < LEN; c++) begin
            es[c] = S_IDL; eb[c] = 0; ed[c] = 1'b0; epd[c] = 1'b0;
        end
        for (int i = 0; i < pl; i++) es[s+i] = S_PRE;
        for (int i = 0; i < n; i++) begin
            es[s+pl+i] = S_DAT;
            eb[s+pl+i] = i;
        end
        ed[s+pl+n-1] = 1'b1;
        for (int i = 0; i < q; i++) es[s+pl+n+i] = S_PST;
        if (q > 0) epd[s+pl+n+q-1] = 1'b1;
    endtask

    task automatic add_cmd(input int t, input int p, input int q, input int n);
        int e, g;
        bit bad;
        bad = 1'b0;
        if (es[t] == S_PRE || es[t] == S_INT) begin
            bad = 1'b1;
        end else if (es[t] == S_IDL || es[t] == S_PST) begin
            write_burst(t + 1, p, q, n);
        end else begin
            e = t;
            while (es[e+1] == S_DAT && eb[e+1] == eb[e] + 1) e++;
            if (es[e+1] == S_DAT || es[e+1] == S_INT) begin
                bad = 1'b1;
            end else begin
                g = p - (e - t);
                if (g < 0) begin
                    bad = 1'b1;
                end else begin
                    for (int c = e + 1; c <= t + p; c++) begin
                        es[c] = S_INT; eb[c] = 0; ed[c] = 1'b0; epd[c] = 1'b0;
                    end
                    write_burst(t + p + 1, 0, q, n);
                end
            end
        end
        if (bad) ee[t+1] = 1'b1;
    endtask

    task automatic build_model(input int L);
        for (int k = 0; k < LEN; k++) begin
            es[k] = S_IDL; eb[k] = 0; ed[k] = 1'b0; epd[k] = 1'b0; ee[k] = 1'b0;
        end
        for (int t = 0; t < L; t++)
            if (cmd_at[t]) add_cmd(t, clampp(cp[t]), int'(cq[t]), (cb[t] == 2'b01) ? 4 : 8);
    endtask

    // Drive edges 0..L-1 and capture cycles 0..L-1 on the falling edge.
    task automatic play(input int L);
        for (int k = 0; k <= L; k++) begin
            @(negedge i_clk);
            if (k > 0) obs[k-1] = outs();
            if (k < L) begin
                i_rd_cmd = cmd_at[k];
                i_precycle = cp[k];
                i_postcycle = cq[k];
                i_burstlength = cb[k];
            end else begin
                i_rd_cmd = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checks++;
            if (outs() !== 11'd0) begin
                errors++;
                $display("FAIL reset_state got %b exp %b", outs(), 11'd0);
            end
        end
    endtask

    task automatic test_single();
        do_reset(); clear_stim();
        set_cmd(0, 2, 1, 0);
        build_model(20); play(20);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++;
                $display("FAIL single cyc %0d got %b exp %b", k, obs[k], expv(k));
            end
        end
        checks++;
        if (obs[3][7] !== 1'b1 || obs[2][7] !== 1'b0) begin
            errors++;
            $display("FAIL single_latency got %b%b exp 10", obs[3][7], obs[2][7]);
        end
        checks++;
        if (obs[11][1] !== 1'b1 || obs[12][9] !== 1'b0) begin
            errors++;
            $display("FAIL single_post got %b%b exp 10", obs[11][1], obs[12][9]);
        end
    endtask

    task automatic test_seamless();
        do_reset(); clear_stim();
        set_cmd(0, 3, 1, 1);
        set_cmd(4, 3, 1, 1);
        build_model(24); play(24);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++;
                $display("FAIL seamless cyc %0d got %b exp %b", k, obs[k], expv(k));
            end
        end
        checks++;
        if (obs[8][7] !== 1'b1 || obs[8][6:4] !== 3'd0 || obs[7][3] !== 1'b1) begin
            errors++;
            $display("FAIL seamless_join got %b exp rdv=1 beat=0 done7=1", obs[8]);
        end
    endtask

    task automatic test_interamble();
        do_reset(); clear_stim();
        set_cmd(0, 2, 1, 0);
        set_cmd(10, 2, 1, 0);
        build_model(30); play(30);
        for (int k = 0; k < 30; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++;
                $display("FAIL inter cyc %0d got %b exp %b", k, obs[k], expv(k));
            end
        end
        checks++;
        if (obs[11][2] !== 1'b1 || obs[12][2] !== 1'b1 || obs[13][7] !== 1'b1 || obs[21][1] !== 1'b1) begin
            errors++;
            $display("FAIL inter_gap got %b %b %b %b exp 1 1 1 1", obs[11][2], obs[12][2], obs[13][7], obs[21][1]);
        end
    endtask

    task automatic test_errors();
        do_reset(); clear_stim();
        set_cmd(0, 2, 1, 0);
        set_cmd(1, 2, 1, 0);
        set_cmd(3, 2, 1, 0);
        build_model(20); play(20);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++;
                $display("FAIL err_run1 cyc %0d got %b exp %b", k, obs[k], expv(k));
            end
        end
        checks++;
        if (obs[2][0] !== 1'b1 || obs[4][0] !== 1'b1 || obs[10][3] !== 1'b1) begin
            errors++;
            $display("FAIL err_pulses got %b %b %b exp 1 1 1", obs[2][0], obs[4][0], obs[10][3]);
        end
        do_reset(); clear_stim();
        set_cmd(0, 2, 1, 0);
        set_cmd(9, 2, 1, 0);
        set_cmd(10, 2, 1, 0);
        build_model(30); play(30);
        for (int k = 0; k < 30; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++;
                $display("FAIL err_run2 cyc %0d got %b exp %b", k, obs[k], expv(k));
            end
        end
        checks++;
        if (obs[11][0] !== 1'b1 || obs[11][2] !== 1'b1 || obs[12][7] !== 1'b1) begin
            errors++;
            $display("FAIL err_pending got %b %b %b exp 1 1 1", obs[11][0], obs[11][2], obs[12][7]);
        end
    endtask

    task automatic test_post_restart();
        do_reset(); clear_stim();
        set_cmd(0, 1, 2, 1);
        set_cmd(6, 1, 2, 1);
        build_model(20); play(20);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++;
                $display("FAIL post_restart cyc %0d got %b exp %b", k, obs[k], expv(k));
            end
        end
        checks++;
        if (obs[7][8] !== 1'b1 || obs[7][1] !== 1'b0 || obs[13][1] !== 1'b1) begin
            errors++;
            $display("FAIL post_trunc got %b %b %b exp 1 0 1", obs[7][8], obs[7][1], obs[13][1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); clear_stim();
        set_cmd(0, 2, 1, 0);
        build_model(6); play(6);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++;
                $display("FAIL rst_pre cyc %0d got %b exp %b", k, obs[k], expv(k));
            end
        end
        i_rst = 1'b0;
        #1;
        checks++;
        if (outs() !== 11'd0) begin
            errors++;
            $display("FAIL rst_async got %b exp %b", outs(), 11'd0);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        clear_stim();
        set_cmd(0, 3, 2, 1);
        build_model(16); play(16);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (obs[k] !== expv(k)) begin
                errors++;
                $display("FAIL rst_post cyc %0d got %b exp %b", k, obs[k], expv(k));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            do_reset(); clear_stim();
            for (int t = 0; t < 60; t++)
                if ($urandom_range(0, 4) == 0) cmd_at[t] = 1'b1;
            build_model(80); play(80);
            for (int k = 0; k < 80; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++;
                    $display("FAIL random it %0d cyc %0d got %b exp %b", it, k, obs[k], expv(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_seamless();
        test_interamble();
        test_errors();
        test_post_restart();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
